dsp_mac_pipeline_v2: RTL and testbench

DSP_MAC_PIPELINE_V2 -- requirements
Module: dsp_mac_pipeline_v2

---
 rtl/dsp_mac_pkg.sv | 38 +++
 rtl/dsp_mac_accbank.sv | 36 +++
 rtl/dsp_mac_pipeline_v2.sv | 241 ++++++++++++++++++++++++
 tb/tb_dsp_mac_pipeline_v2.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_mac_pkg.sv
// Shared command encodings and the decoded command struct for the MAC pipeline.
package dsp_mac_pkg;

    localparam int unsigned CMD_W       = 5;
    localparam int unsigned CMD_PRE_LSB = 0;
    localparam int unsigned CMD_ACC_LSB = 2;
    localparam int unsigned CMD_RND_BIT = 4;

    typedef enum logic [1:0] {
        PRE_A    = 2'b00,
        PRE_ZERO = 2'b01,
        PRE_DPA  = 2'b10,
        PRE_DMA  = 2'b11
    } pre_mode_e;

    typedef enum logic [1:0] {
        ACC_LOAD = 2'b00,
        ACC_ADD  = 2'b01,
        ACC_CADD = 2'b10,
        ACC_SUB  = 2'b11
    } acc_mode_e;

    typedef struct packed {
        logic      rnd;
        acc_mode_e acc;
        pre_mode_e pre;
    } mac_cmd_t;

    // Split the raw command word into its fields.
    function automatic mac_cmd_t decode_cmd(input logic [CMD_W-1:0] raw);
        mac_cmd_t cmd;
        cmd.pre = pre_mode_e'(raw[CMD_PRE_LSB +: 2]);
        cmd.acc = acc_mode_e'(raw[CMD_ACC_LSB +: 2]);
        cmd.rnd = raw[CMD_RND_BIT];
        return cmd;
    endfunction

endpackage

// File: rtl/dsp_mac_accbank.sv
// Per-channel accumulator storage: one combinational read port, one write port,
// and a global clear that takes priority over the write.
module dsp_mac_accbank #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned P_WIDTH  = 48,
    parameter int unsigned CH_W     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               wr_en,
    input  logic [CH_W-1:0]    wr_ch,
    input  logic [P_WIDTH-1:0] wr_data,
    input  logic [CH_W-1:0]    rd_ch,
    output logic [P_WIDTH-1:0] rd_data_c
);

    logic [P_WIDTH-1:0] acc_q [CHANNELS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= '0;
            end
        end else if (clr) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= '0;
            end
        end else if (wr_en) begin
            acc_q[wr_ch] <= wr_data;
        end
    end

    assign rd_data_c = acc_q[rd_ch];

endmodule

// File: rtl/dsp_mac_pipeline_v2.sv
// Four-stage pre-add / multiply / accumulate pipeline with per-channel accumulators.
// Optional e3 saturation is enabled by defining DSP_MAC_PIPELINE_SAT_EN.
module dsp_mac_pipeline_v2
    import dsp_mac_pkg::*;
#(
    parameter int unsigned A_WIDTH   = 25,
    parameter int unsigned B_WIDTH   = 18,
    parameter int unsigned P_WIDTH   = 48,
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned TAG_WIDTH = 1,
    parameter int unsigned RND_SHIFT = 17,
    localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [A_WIDTH-1:0]   s_a,
    input  logic [A_WIDTH-1:0]   s_d,
    input  logic [B_WIDTH-1:0]   s_b,
    input  logic [CMD_W-1:0]     s_cmd,
    input  logic [CH_W-1:0]      s_ch,
    input  logic [TAG_WIDTH-1:0] s_tag,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [P_WIDTH-1:0]   s_c_data,
    input  logic                 s_c_valid,
    input  logic                 s_acc_clr,
    output logic [P_WIDTH-1:0]   m_p_data,
    output logic [CH_W-1:0]      m_p_ch,
    output logic [TAG_WIDTH-1:0] m_p_tag,
    output logic                 m_p_valid,
    input  logic                 m_p_ready,
    output logic                 m_p_sat
);

    localparam int unsigned PRE_W  = A_WIDTH + 1;
    localparam int unsigned PROD_W = A_WIDTH + B_WIDTH + 1;
    localparam int unsigned M_W    = P_WIDTH + 1;
    localparam logic signed [M_W-1:0] RND_CONST = M_W'(1) <<< (RND_SHIFT - 1);

    if (P_WIDTH < A_WIDTH + B_WIDTH + 2) begin : g_width_check
        $error("dsp_mac_pipeline_v2: P_WIDTH too narrow for A_WIDTH/B_WIDTH");
    end

    // Whole pipeline moves in lockstep; only the output handshake can stall it.
    logic adv_c;
    assign adv_c   = !m_p_valid || m_p_ready;
    assign s_ready = adv_c;

    // e0: input capture
    logic [A_WIDTH-1:0]   a0, d0;
    logic [B_WIDTH-1:0]   b0;
    mac_cmd_t             cmd0;
    logic [CH_W-1:0]      ch0;
    logic [TAG_WIDTH-1:0] tag0;
    logic                 v0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0   <= 1'b0;
            a0   <= '0;
            d0   <= '0;
            b0   <= '0;
            cmd0 <= '0;
            ch0  <= '0;
            tag0 <= '0;
        end else if (adv_c) begin
            v0   <= s_valid;
            a0   <= s_a;
            d0   <= s_d;
            b0   <= s_b;
            cmd0 <= decode_cmd(s_cmd);
            ch0  <= s_ch;
            tag0 <= s_tag;
        end
    end

    // e1: pre-adder, one bit wider than A so D+/-A never wraps
    logic signed [PRE_W-1:0] a_ext_c, d_ext_c, pre_c;

    always_comb begin
        a_ext_c = PRE_W'(signed'(a0));
        d_ext_c = PRE_W'(signed'(d0));
        pre_c   = '0;
        case (cmd0.pre)
            PRE_A:    pre_c = a_ext_c;
            PRE_ZERO: pre_c = '0;
            PRE_DPA:  pre_c = d_ext_c + a_ext_c;
            PRE_DMA:  pre_c = d_ext_c - a_ext_c;
            default:  pre_c = '0;
        endcase
    end

    logic signed [PRE_W-1:0]   pre1;
    logic signed [B_WIDTH-1:0] b1;
    acc_mode_e                 acc1;
    logic                      rnd1;
    logic [CH_W-1:0]           ch1;
    logic [TAG_WIDTH-1:0]      tag1;
    logic                      v1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            pre1 <= '0;
            b1   <= '0;
            acc1 <= ACC_LOAD;
            rnd1 <= 1'b0;
            ch1  <= '0;
            tag1 <= '0;
        end else if (adv_c) begin
            v1   <= v0;
            pre1 <= pre_c;
            b1   <= signed'(b0);
            acc1 <= cmd0.acc;
            rnd1 <= cmd0.rnd;
            ch1  <= ch0;
            tag1 <= tag0;
        end
    end

    // e2: signed multiply, sign-extended to the sum width
    logic signed [PROD_W-1:0] prod_c;
    assign prod_c = PROD_W'(pre1) * PROD_W'(b1);

    logic signed [M_W-1:0] m2;
    acc_mode_e             acc2;
    logic                  rnd2;
    logic [CH_W-1:0]       ch2;
    logic [TAG_WIDTH-1:0]  tag2;
    logic                  v2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2   <= 1'b0;
            m2   <= '0;
            acc2 <= ACC_LOAD;
            rnd2 <= 1'b0;
            ch2  <= '0;
            tag2 <= '0;
        end else if (adv_c) begin
            v2   <= v1;
            m2   <= M_W'(prod_c);
            acc2 <= acc1;
            rnd2 <= rnd1;
            ch2  <= ch1;
            tag2 <= tag1;
        end
    end

    // C operand loads independently of the pipeline handshake.
    logic [P_WIDTH-1:0] c_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q <= '0;
        end else if (s_c_valid) begin
            c_q <= s_c_data;
        end
    end

    // e3: accumulate; the bank is written at the same edge as the output register,
    // so a following same-channel op reads the fresh value with no forwarding.
    logic [P_WIDTH-1:0]    acc_rd_c;
    logic signed [M_W-1:0] acc_ext_c, c_ext_c, sum_c;
    logic [P_WIDTH-1:0]    res_c;
    logic                  sat_c;
    logic                  acc_we_c;

    always_comb begin
        acc_ext_c = M_W'(signed'(acc_rd_c));
        c_ext_c   = M_W'(signed'(c_q));
        sum_c     = m2;
        case (acc2)
            ACC_LOAD: sum_c = m2;
            ACC_ADD:  sum_c = acc_ext_c + m2;
            ACC_CADD: sum_c = c_ext_c + m2;
            ACC_SUB:  sum_c = acc_ext_c - m2;
            default:  sum_c = m2;
        endcase
        if (rnd2) begin
            sum_c = sum_c + RND_CONST;
        end
    end

`ifdef DSP_MAC_PIPELINE_SAT_EN
    localparam logic [P_WIDTH-1:0] P_MAX = {1'b0, {(P_WIDTH-1){1'b1}}};
    localparam logic [P_WIDTH-1:0] P_MIN = {1'b1, {(P_WIDTH-1){1'b0}}};

    // Overflow shows up as disagreement between the guard bit and the P sign bit.
    always_comb begin
        res_c = sum_c[P_WIDTH-1:0];
        sat_c = 1'b0;
        if (sum_c[P_WIDTH] != sum_c[P_WIDTH-1]) begin
            sat_c = 1'b1;
            res_c = sum_c[P_WIDTH] ? P_MIN : P_MAX;
        end
    end
`else
    logic unused_sum_msb;
    assign unused_sum_msb = sum_c[P_WIDTH];
    assign res_c          = sum_c[P_WIDTH-1:0];
    assign sat_c          = 1'b0;
`endif

    assign acc_we_c = v2 && adv_c;

    dsp_mac_accbank #(
        .CHANNELS (CHANNELS),
        .P_WIDTH  (P_WIDTH),
        .CH_W     (CH_W)
    ) u_accbank (
        .clk       (clk),
        .rst       (rst),
        .clr       (s_acc_clr),
        .wr_en     (acc_we_c),
        .wr_ch     (ch2),
        .wr_data   (res_c),
        .rd_ch     (ch2),
        .rd_data_c (acc_rd_c)
    );

    // Output register; payload only changes when a new valid result lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_p_valid <= 1'b0;
            m_p_data  <= '0;
            m_p_ch    <= '0;
            m_p_tag   <= '0;
            m_p_sat   <= 1'b0;
        end else if (adv_c) begin
            m_p_valid <= v2;
            if (v2) begin
                m_p_data <= res_c;
                m_p_ch   <= ch2;
                m_p_tag  <= tag2;
                m_p_sat  <= sat_c;
            end
        end
    end

endmodule

// File: tb/tb_dsp_mac_pipeline_v2.sv
// Scoreboard bench for dsp_mac_pipeline_v2: a reference model predicts each result
// when it is accepted and the output monitor compares in order.
module tb_dsp_mac_pipeline_v2;

    localparam int unsigned A_W  = 25;
    localparam int unsigned B_W  = 18;
    localparam int unsigned P_W  = 48;
    localparam int unsigned CHN  = 4;
    localparam int unsigned CH_W = 2;
    localparam int unsigned T_W  = 4;
    localparam int unsigned RND  = 17;
    localparam longint PMAX = (longint'(1) <<< (P_W - 1)) - 1;
    localparam longint PMIN = -PMAX - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [A_W-1:0]   s_a, s_d;
    logic [B_W-1:0]   s_b;
    logic [4:0]       s_cmd;
    logic [CH_W-1:0]  s_ch;
    logic [T_W-1:0]   s_tag;
    logic             s_valid, s_ready;
    logic [P_W-1:0]   s_c_data;
    logic             s_c_valid, s_acc_clr;
    logic [P_W-1:0]   m_p_data;
    logic [CH_W-1:0]  m_p_ch;
    logic [T_W-1:0]   m_p_tag;
    logic             m_p_valid, m_p_ready, m_p_sat;

    dsp_mac_pipeline_v2 #(
        .A_WIDTH(A_W), .B_WIDTH(B_W), .P_WIDTH(P_W),
        .CHANNELS(CHN), .TAG_WIDTH(T_W), .RND_SHIFT(RND)
    ) dut (
        .clk(clk), .rst(rst),
        .s_a(s_a), .s_d(s_d), .s_b(s_b), .s_cmd(s_cmd), .s_ch(s_ch), .s_tag(s_tag),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_c_data(s_c_data), .s_c_valid(s_c_valid), .s_acc_clr(s_acc_clr),
        .m_p_data(m_p_data), .m_p_ch(m_p_ch), .m_p_tag(m_p_tag),
        .m_p_valid(m_p_valid), .m_p_ready(m_p_ready), .m_p_sat(m_p_sat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [P_W-1:0]  data;
        logic [CH_W-1:0] ch;
        logic [T_W-1:0]  tag;
        logic            sat;
        int              cyc;
    } exp_t;

    exp_t   sbq[$];
    longint macc[CHN];
    longint mc;
    int     n_chk  = 0;
    int     n_fail = 0;
    bit     lat_chk = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: evaluates one accepted transaction and queues its result.
    task automatic model_push(input longint a, input longint d, input longint b,
                              input logic [4:0] cmd, input logic [CH_W-1:0] ch,
                              input logic [T_W-1:0] tag);
        longint pre, m, p;
        logic [1:0] pm, am;
        exp_t e;
        logic sat = 1'b0;
        pm = cmd[1:0];
        am = cmd[3:2];
        case (pm)
            2'd0: pre = a;
            2'd1: pre = 0;
            2'd2: pre = d + a;
            default: pre = d - a;
        endcase
        m = pre * b;
        case (am)
            2'd0: p = m;
            2'd1: p = macc[ch] + m;
            2'd2: p = mc + m;
            default: p = macc[ch] - m;
        endcase
        if (cmd[4]) p = p + (longint'(1) <<< (RND - 1));
`ifdef DSP_MAC_PIPELINE_SAT_EN
        if (p > PMAX) begin p = PMAX; sat = 1'b1; end
        else if (p < PMIN) begin p = PMIN; sat = 1'b1; end
`else
        p = (p <<< (64 - P_W)) >>> (64 - P_W);
`endif
        macc[ch] = p;
        e.data = P_W'(p);
        e.ch   = ch;
        e.tag  = tag;
        e.sat  = sat;
        e.cyc  = cyc;
        sbq.push_back(e);
    endtask

    // Offer one transaction and hold it until accepted; returns just after the accepting edge.
    task automatic send(input longint a, input longint d, input longint b, input logic [4:0] cmd,
                        input logic [CH_W-1:0] ch, input logic [T_W-1:0] tag);
        bit done = 1'b0;
        s_a = A_W'(a); s_d = A_W'(d); s_b = B_W'(b);
        s_cmd = cmd; s_ch = ch; s_tag = tag; s_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (s_ready) begin
                model_push(a, d, b, cmd, ch, tag);
                done = 1'b1;
            end
            @(posedge clk); #2;
        end
        s_valid = 1'b0;
        if (!done) chk("send_timeout", 64'(done), 64'd1);
    endtask

    task automatic drain();
        int k = 0;
        while (sbq.size() != 0 && k < 200) begin
            @(posedge clk); #2;
            k++;
        end
        @(posedge clk); #2;
        if (sbq.size() != 0) chk("drain_timeout", 64'(sbq.size()), 64'd0);
    endtask

    task automatic clear_acc();
        s_acc_clr = 1'b1;
        @(posedge clk); #2;
        s_acc_clr = 1'b0;
        for (int i = 0; i < CHN; i++) macc[i] = 0;
    endtask

    task automatic load_c(input longint v);
        s_c_data = P_W'(v);
        s_c_valid = 1'b1;
        @(posedge clk); #2;
        s_c_valid = 1'b0;
        mc = v;
    endtask

    // Output monitor: samples mid-cycle, compares consumed results, checks stall hold.
    logic [P_W-1:0]  held_data;
    logic [CH_W-1:0] held_ch;
    logic [T_W-1:0]  held_tag;
    logic            held_sat;
    bit              stalled_prev = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && m_p_valid) begin
                if (stalled_prev) begin
                    chk("hold_data", 64'(m_p_data), 64'(held_data));
                    chk("hold_tag", 64'(m_p_tag), 64'(held_tag));
                    chk("hold_ch_sat", 64'({m_p_ch, m_p_sat}), 64'({held_ch, held_sat}));
                end
                if (!m_p_ready) begin
                    held_data = m_p_data; held_ch = m_p_ch;
                    held_tag = m_p_tag; held_sat = m_p_sat;
                    stalled_prev = 1'b1;
                end else begin
                    stalled_prev = 1'b0;
                    if (sbq.size() == 0) begin
                        chk("unexpected_out", 64'(m_p_valid), 64'd0);
                    end else begin
                        e = sbq.pop_front();
                        chk("data", 64'(m_p_data), 64'(e.data));
                        chk("ch", 64'(m_p_ch), 64'(e.ch));
                        chk("tag", 64'(m_p_tag), 64'(e.tag));
                        chk("sat", 64'(m_p_sat), 64'(e.sat));
                        if (lat_chk) chk("latency", 64'(cyc - e.cyc), 64'd4);
                    end
                end
            end else begin
                stalled_prev = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit saw_low;
        rst = 1'b1; s_valid = 1'b0; s_a = '0; s_d = '0; s_b = '0; s_cmd = '0;
        s_ch = '0; s_tag = '0; s_c_data = '0; s_c_valid = 1'b0; s_acc_clr = 1'b0;
        m_p_ready = 1'b1;
        mc = 0;
        for (int i = 0; i < CHN; i++) macc[i] = 0;
        repeat (3) @(posedge clk); #2;
        chk("rst_valid", 64'(m_p_valid), 64'd0);
        chk("rst_sready", 64'(s_ready), 64'd1);
        chk("rst_data", 64'(m_p_data), 64'd0);
        chk("rst_sat", 64'(m_p_sat), 64'd0);
        rst = 1'b0;
        @(posedge clk); #2;

        // Plain multiply, exact latency.
        lat_chk = 1'b1;
        send(3, 0, 5, 5'b00000, 0, 1);
        drain();

        // Back-to-back same-channel accumulate: 2,4,6,8.
        clear_acc();
        for (int i = 0; i < 4; i++) send(1, 0, 2, 5'b00100, 0, T_W'(i));
        drain();

        // Interleaved channels: ch0 1,2 and ch1 2,4.
        clear_acc();
        send(1, 0, 1, 5'b00100, 0, 0);
        send(2, 0, 1, 5'b00100, 1, 1);
        send(1, 0, 1, 5'b00100, 0, 2);
        send(2, 0, 1, 5'b00100, 1, 3);
        drain();

        // Pre-add modes, C path, subtract and rounding.
        load_c(123456789);
        send(-7, 100, -3, 5'b00010, 2, 4);
        send(16777215, -16777216, 131071, 5'b00011, 2, 5);
        send(55, 66, 77, 5'b00101, 2, 6);
        send(-1000, 0, 1000, 5'b01000, 3, 7);
        send(300, 20, -5, 5'b01111, 2, 8);
        send(1000, 0, 1000, 5'b10000, 1, 9);
        send(-16777216, -16777216, -131072, 5'b10110, 0, 10);
        drain();

        // Random traffic under random backpressure.
        lat_chk = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    send(longint'($urandom_range(0, 33554431)) - 16777216,
                         longint'($urandom_range(0, 33554431)) - 16777216,
                         longint'($urandom_range(0, 262143)) - 131072,
                         5'($urandom_range(0, 31)), CH_W'($urandom_range(0, 3)), T_W'(i));
                end
            end
            begin
                repeat (60) begin
                    @(posedge clk); #2;
                    m_p_ready = 1'($urandom_range(0, 1));
                end
                m_p_ready = 1'b1;
            end
        join
        m_p_ready = 1'b1;
        drain();

        // Five-cycle stall with six offers: ready must drop, order preserved.
        saw_low = 1'b0;
        fork
            begin
                repeat (3) @(posedge clk);
                #2 m_p_ready = 1'b0;
                repeat (5) @(posedge clk);
                #2 m_p_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 6; i++) send(i + 1, 0, 3, 5'b00000, 2, T_W'(8 + i));
            end
            begin
                repeat (12) begin
                    @(negedge clk);
                    if (!s_ready) saw_low = 1'b1;
                end
            end
        join
        chk("s_ready_dropped", 64'(saw_low), 64'd1);
        drain();

        // Overflow at positive full scale.
        lat_chk = 1'b1;
        load_c(PMAX - 1);
        send(1, 0, 1, 5'b01000, 3, 1);
        send(1, 0, 1, 5'b00100, 3, 2);
        drain();

        // Clear coincident with an e3 write: result still emitted, ACC cleared.
        clear_acc();
        send(5, 0, 1, 5'b00100, 0, 3);
        @(posedge clk); @(posedge clk); #2;
        s_acc_clr = 1'b1;
        @(posedge clk); #2;
        s_acc_clr = 1'b0;
        for (int i = 0; i < CHN; i++) macc[i] = 0;
        send(1, 0, 1, 5'b00100, 0, 4);
        drain();

        // Reset with three transactions in flight.
        send(7, 0, 1, 5'b00100, 1, 5);
        send(7, 0, 1, 5'b00100, 1, 6);
        send(7, 0, 1, 5'b00100, 1, 7);
        rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(m_p_valid), 64'd0);
        chk("midrst_sready", 64'(s_ready), 64'd1);
        sbq.delete();
        for (int i = 0; i < CHN; i++) macc[i] = 0;
        mc = 0;
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        send(1, 0, 1, 5'b00100, 1, 8);
        send(2, 0, 3, 5'b01000, 0, 9);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
